// File: rtl/sha3_padder_if.sv
// ---------------------------------------------------------------------------
// sha3_padder_if
//   Bundles the two streams around the SHA3 padder:
//     byte side  : in_data, in_valid, in_last (towards the padder), in_ready (back)
//     block side : block, block_valid, block_last (towards keccak), block_ready (back)
//   Parameter R is the rate in bits and must equal 1600 - 2*d of the padder.
//   Modports:
//     master : the environment (byte source plus block sink)
//     slave  : the padder itself
// ---------------------------------------------------------------------------
interface sha3_padder_if #(
   parameter int R = 1088
);
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [R-1:0] block;
   logic         block_valid;
   logic         block_ready;
   logic         block_last;

   modport master (
      output in_data, in_valid, in_last, block_ready,
      input  in_ready, block, block_valid, block_last
   );

   modport slave (
      input  in_data, in_valid, in_last, block_ready,
      output in_ready, block, block_valid, block_last
   );
endinterface

// File: rtl/sha3_padder.sv
// ---------------------------------------------------------------------------
// sha3_padder
//   Front end for the keccak sponge. Collects a byte stream into r-bit rate
//   blocks (first byte in the top byte of the block) and applies SHA3 domain
//   separation plus pad10*1 padding to the final block of every message.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high reset
//     bus    : sha3_padder_if.slave carrying the byte stream in and the
//              block stream out (see the interface header)
//   Parameter D is the digest width (224/256/384/512); rate R = 1600 - 2*D.
// ---------------------------------------------------------------------------
module sha3_padder #(
   parameter int D = 256
) (
   input  logic        clk,
   input  logic        reset,
   sha3_padder_if.slave bus
);
   localparam int R  = 1600 - 2 * D;
   localparam int NB = R / 8;
   localparam logic [7:0]   LAST_POS = 8'(NB - 1);
   localparam logic [R-1:0] PAD_ONLY = {8'h60, {(R - 16){1'b0}}, 8'h01};

   typedef enum logic {
      FILL,
      HOLD
   } state_t;

   state_t       state_q, state_d;
   logic [7:0]   count_q, count_d;
   logic [R-1:0] block_q, block_d;
   logic         block_valid_q, block_valid_d;
   logic         block_last_q, block_last_d;
   logic         pending_pad_q, pending_pad_d;
   logic [7:0]   next_pos;
   logic         pad_now;

   // State register: every flop of the padder, cleared together on reset so a
   // partial block or an outstanding padding block is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FILL;
         count_q       <= '0;
         block_q       <= '0;
         block_valid_q <= 1'b0;
         block_last_q  <= 1'b0;
         pending_pad_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         block_q       <= block_d;
         block_valid_q <= block_valid_d;
         block_last_q  <= block_last_d;
         pending_pad_q <= pending_pad_d;
      end
   end

   // Next-state logic. In FILL each accepted byte lands at position count;
   // a last byte that leaves room in the block also writes the pad bytes on
   // the same edge. Bytes above the pad start are forced to zero because the
   // register still holds the previous block's data. A last byte that fills
   // the block defers padding to a separate padding-only block.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      block_d       = block_q;
      block_valid_d = block_valid_q;
      block_last_d  = block_last_q;
      pending_pad_d = pending_pad_q;
      next_pos      = count_q + 8'd1;
      pad_now       = bus.in_last && (count_q != LAST_POS);

      unique case (state_q)
         FILL: begin
            if (bus.in_valid) begin
               count_d = next_pos;
               for (int k = 0; k < NB; k++) begin
                  if (8'(k) == count_q) begin
                     block_d[R-1-8*k -: 8] = bus.in_data;
                  end else if (pad_now && (8'(k) == next_pos)) begin
                     block_d[R-1-8*k -: 8] = 8'h60;
                  end else if (pad_now && (8'(k) > next_pos)) begin
                     block_d[R-1-8*k -: 8] = 8'h00;
                  end
               end
               // Terminal pad bit; merges with 0x60 into 0x61 when adjacent.
               if (pad_now) begin
                  block_d[7:0] = block_d[7:0] | 8'h01;
               end
               if (bus.in_last || (count_q == LAST_POS)) begin
                  state_d       = HOLD;
                  block_valid_d = 1'b1;
                  block_last_d  = pad_now;
                  pending_pad_d = bus.in_last && (count_q == LAST_POS);
               end
            end
         end
         HOLD: begin
            if (block_valid_q && bus.block_ready) begin
               count_d = '0;
               if (pending_pad_q) begin
                  block_d       = PAD_ONLY;
                  block_valid_d = 1'b1;
                  block_last_d  = 1'b1;
                  pending_pad_d = 1'b0;
               end else begin
                  block_valid_d = 1'b0;
                  block_last_d  = 1'b0;
                  state_d       = FILL;
               end
            end
         end
      endcase
   end

   // Outputs: the block side comes straight from flops; in_ready is forced
   // low while reset is asserted so no byte is taken during reset.
   always_comb begin
      bus.in_ready    = (state_q == FILL) && !reset;
      bus.block       = block_q;
      bus.block_valid = block_valid_q;
      bus.block_last  = block_last_q;
   end
endmodule
